// File: rtl/sp_mem_arbiter.sv
// Round-robin arbiter with bounded hold sharing one single-port MEM.
// Optional MEM_ARB_PERF_EN adds per-port grant/wait counters.
module sp_mem_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    output logic          mem_wen,
    input  logic [DW-1:0] mem_q
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]   gcnt0,
    output logic [15:0]   gcnt1,
    output logic [15:0]   wcnt0,
    output logic [15:0]   wcnt1
`endif
);

    localparam logic [3:0] MAX_H = 4'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] hold_cnt;
    logic       rr_next;
    logic       rv0_q;
    logic       rv1_q;
    logic       wr0;
    logic       wr1;
    logic       both;
    logic       held_out;

    assign both     = req0 & req1;
    assign held_out = (hold_cnt >= MAX_H);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (both) begin
                        gnt0 = ~rr_next;
                        gnt1 = rr_next;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                OWN0: begin
                    if (both) begin
                        gnt0 = ~held_out;
                        gnt1 = held_out;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                OWN1: begin
                    if (both) begin
                        gnt1 = ~held_out;
                        gnt0 = held_out;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                default: begin
                    gnt0 = 1'b0;
                    gnt1 = 1'b0;
                end
            endcase
        end
    end

    assign wr0 = gnt0 & we0;
    assign wr1 = gnt1 & we1;

    always_comb begin
        mem_a   = '0;
        mem_d   = '0;
        mem_wen = 1'b1;
        unique case (1'b1)
            gnt0: begin
                mem_a   = addr0;
                mem_d   = wr0 ? wdata0 : '0;
                mem_wen = ~wr0;
            end
            gnt1: begin
                mem_a   = addr1;
                mem_d   = wr1 ? wdata1 : '0;
                mem_wen = ~wr1;
            end
            default: begin
                mem_a   = '0;
                mem_d   = '0;
                mem_wen = 1'b1;
            end
        endcase
    end

    // Staying with the current owner bumps the hold count; any switch restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= 4'd0;
            rr_next  <= 1'b0;
            rv0_q    <= 1'b0;
            rv1_q    <= 1'b0;
        end else begin
            rv0_q <= gnt0 & ~we0;
            rv1_q <= gnt1 & ~we1;
            if (gnt0) begin
                state   <= OWN0;
                rr_next <= 1'b1;
                if (state == OWN0)
                    hold_cnt <= held_out ? hold_cnt : hold_cnt + 4'd1;
                else
                    hold_cnt <= 4'd1;
            end else if (gnt1) begin
                state   <= OWN1;
                rr_next <= 1'b0;
                if (state == OWN1)
                    hold_cnt <= held_out ? hold_cnt : hold_cnt + 4'd1;
                else
                    hold_cnt <= 4'd1;
            end else begin
                state    <= IDLE;
                hold_cnt <= 4'd0;
            end
        end
    end

    // Reset squashes a return that was already in flight.
    assign rvalid0 = rv0_q & ~rst;
    assign rvalid1 = rv1_q & ~rst;
    assign rdata0  = rvalid0 ? mem_q : '0;
    assign rdata1  = rvalid1 ? mem_q : '0;

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt0 <= 16'd0;
            gcnt1 <= 16'd0;
            wcnt0 <= 16'd0;
            wcnt1 <= 16'd0;
        end else begin
            if (req0 && gnt0 && gcnt0 != 16'hFFFF)
                gcnt0 <= gcnt0 + 16'd1;
            if (req1 && gnt1 && gcnt1 != 16'hFFFF)
                gcnt1 <= gcnt1 + 16'd1;
            if (req0 && !gnt0 && wcnt0 != 16'hFFFF)
                wcnt0 <= wcnt0 + 16'd1;
            if (req1 && !gnt1 && wcnt1 != 16'hFFFF)
                wcnt1 <= wcnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Directed bench for sp_mem_arbiter with a read-return scoreboard.
// Define MEM_ARB_PERF_EN to also check the perf counters.
module tb_sp_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic          mem_wen;
    logic [DW-1:0] mem_q;
`ifdef MEM_ARB_PERF_EN
    logic [15:0]   gcnt0, gcnt1, wcnt0, wcnt1;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem [0:4095];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];

    sp_mem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_a(mem_a), .mem_d(mem_d), .mem_wen(mem_wen), .mem_q(mem_q)
`ifdef MEM_ARB_PERF_EN
        , .gcnt0(gcnt0), .gcnt1(gcnt1), .wcnt0(wcnt0), .wcnt1(wcnt1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem_q = '0;
    end

    always @(posedge clk) begin
        if (!mem_wen) mem[mem_a] <= mem_d;
        mem_q <= mem[mem_a];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'd0;
    endfunction

    // One clock cycle: check outputs mid-cycle, then advance past the edge.
    task automatic step(input logic eg0, input logic eg1, input string tag);
        logic          ew0, ew1;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [DW-1:0] v;
        @(negedge clk);
        if (rst) begin
            q0.delete();
            q1.delete();
        end
        chk({tag, ".rvalid0"}, 32'(rvalid0), 32'(q0.size() > 0));
        v = (q0.size() > 0) ? q0.pop_front() : 32'd0;
        chk({tag, ".rdata0"}, rdata0, v);
        chk({tag, ".rvalid1"}, 32'(rvalid1), 32'(q1.size() > 0));
        v = (q1.size() > 0) ? q1.pop_front() : 32'd0;
        chk({tag, ".rdata1"}, rdata1, v);
        chk({tag, ".gnt0"}, 32'(gnt0), 32'(eg0));
        chk({tag, ".gnt1"}, 32'(gnt1), 32'(eg1));
        ew0 = eg0 && we0;
        ew1 = eg1 && we1;
        ea  = eg0 ? addr0 : (eg1 ? addr1 : '0);
        ed  = ew0 ? wdata0 : (ew1 ? wdata1 : '0);
        chk({tag, ".mem_wen"}, 32'(mem_wen), 32'(!(ew0 || ew1)));
        chk({tag, ".mem_a"}, 32'(mem_a), 32'(ea));
        if (ew0 || ew1) chk({tag, ".mem_d"}, mem_d, ed);
        if (eg0) begin
            if (we0) ref_mem[int'(addr0)] = wdata0;
            else q0.push_back(ref_rd(addr0));
        end
        if (eg1) begin
            if (we1) ref_mem[int'(addr1)] = wdata1;
            else q1.push_back(ref_rd(addr1));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic e;
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        step(0, 0, "rst_a");
        step(0, 0, "rst_b");
        rst = 1'b0;

        // Continuous contention from IDLE: blocks of four grants.
        req0 = 1; we0 = 0; addr0 = 12'h020;
        req1 = 1; we1 = 0; addr1 = 12'h030;
        for (int i = 0; i < 16; i++) begin
            e = ((i / 4) % 2) == 0;
            step(e, !e, $sformatf("rr%0d", i));
        end
`ifdef MEM_ARB_PERF_EN
        chk("gcnt0", 32'(gcnt0), 32'd8);
        chk("gcnt1", 32'(gcnt1), 32'd8);
        chk("wcnt0", 32'(wcnt0), 32'd8);
        chk("wcnt1", 32'(wcnt1), 32'd8);
`endif
        req0 = 0; req1 = 0;
        step(0, 0, "rr_idle");

        // Port 1 write then read back of the same address.
        req1 = 1; we1 = 1; addr1 = 12'h010; wdata1 = 32'hDEADBEEF;
        step(0, 1, "p1_wr");
        we1 = 0;
        step(0, 1, "p1_rd");
        req1 = 0;
        step(0, 0, "p1_ret");

        // Preload more words through port 1.
        req1 = 1; we1 = 1;
        for (int i = 1; i < 6; i++) begin
            addr1  = 12'h010 + 12'(i);
            wdata1 = 32'hA5A50000 + 32'(i * 17);
            step(0, 1, $sformatf("pre%0d", i));
        end
        req1 = 0; we1 = 0;

        // Port 0 streams six reads.
        req0 = 1; we0 = 0;
        for (int i = 0; i < 6; i++) begin
            addr0 = 12'h010 + 12'(i);
            step(1, 0, $sformatf("s%0d", i));
        end
        req0 = 0;
        step(0, 0, "s_tail");

        rst = 1'b1;
        step(0, 0, "rst2");
        rst = 1'b0;

        // Round-robin pointer after reset, then after a grant to port 0.
        step(0, 0, "t4_idle0");
        req0 = 1; we0 = 0; addr0 = 12'h012;
        req1 = 1; we1 = 0; addr1 = 12'h013;
        step(1, 0, "t4_w0");
        req0 = 0; req1 = 0;
        step(0, 0, "t4_idle1");
        req0 = 1; req1 = 1;
        step(0, 1, "t4_w1");
        req0 = 0; req1 = 0;
        step(0, 0, "t4_idle2");

        // Reset right after an accepted read; request held through reset.
        req0 = 1; we0 = 0; addr0 = 12'h011;
        step(1, 0, "t5_rd");
        req0 = 0;
        rst = 1'b1;
        req1 = 1; we1 = 0; addr1 = 12'h014;
        step(0, 0, "t5_rst");
        rst = 1'b0;
        step(0, 1, "t5_rel");
        req1 = 0;
        step(0, 0, "t5_ret");
        step(0, 0, "t5_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sp_mem_arbiter.md
Name: sp_mem_arbiter

Overview:
- Two-port arbiter that shares the single-port data MEM between two requesters.
- Port 0 is the SP data port. Port 1 is the bench-side loader/debug port, used for preload and result readback.
- Drives the MEM address, write data and active-low write enable.
- Returns read data one cycle after grant.
- Uses a round-robin scheme with a bounded hold, so neither port starves.

Parameters:
AW, 12, MEM address width
DW, 32, MEM data width
MAX_HOLD, 4, max consecutive grants to one port while the other port is requesting (range 1..15)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
req0  in  1  port 0 request; must hold req0/we0/addr0/wdata0 stable until gnt0
we0  in  1  port 0: 1=write, 0=read
addr0  in  AW  port 0 address
wdata0  in  DW  port 0 write data
gnt0  out  1  port 0 grant; transfer accepted on an edge where req0&gnt0
rvalid0  out  1  port 0 read data valid
rdata0  out  DW  port 0 read data
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  port 1 equivalents of the port 0 signals
mem_a  out  AW  MEM address
mem_d  out  DW  MEM write data
mem_wen  out  1  MEM write enable, active-low (0=write)
mem_q  in  DW  MEM read data; valid after the edge that sampled the address

Behaviour:
Grant timing
- gnt0/gnt1 are combinational from req0/req1 and the registered state. At most one grant per cycle; gnt never asserts without its req.
- MEM outputs are combinational from the granted port. With no grant: mem_wen=1, mem_a=0, mem_d=0.
- Granted write: mem_wen=0, mem_a=addrN, mem_d=wdataN.

State machine
- States: IDLE, OWN0, OWN1.
- Registers: hold_cnt (4 bits, saturates at MAX_HOLD) and rr_next (the port favoured when both request from IDLE; 0 after reset).
- IDLE:
  - Only one port requesting: that port is granted.
  - Both requesting: port rr_next is granted.
  - Next state is OWN<granted>; hold_cnt=1.
- OWNk:
  - Only the other port requesting: switch to it; hold_cnt=1.
  - Only port k requesting: port k is granted; hold_cnt increments, saturating.
  - Both requesting, hold_cnt<MAX_HOLD: port k is granted; hold_cnt++.
  - Both requesting, hold_cnt==MAX_HOLD: the other port is granted, becomes owner; hold_cnt=1.
- No request in a cycle: go to IDLE; hold_cnt=0; rr_next = the port not most recently granted.
- On every grant, rr_next becomes the non-granted port.

Read return
- An accepted read sets rvalidN=1 for exactly the next cycle, with rdataN=mem_q. Read latency is 1 cycle.
- When rvalidN=0, rdataN=0.
- Writes produce no rvalid.
- Back-to-back reads by one port give rvalid on consecutive cycles.
- Interleaved ports: each rvalid goes only to the port that was granted in the previous cycle.

Reset
- While rst=1, all outputs are forced:
  - gnt0=gnt1=0, rvalid0=rvalid1=0
  - mem_wen=1, mem_a=0, mem_d=0
- Register state: IDLE, hold_cnt=0, rr_next=0.
- Reset asserted the cycle after an accepted read squashes that rvalid.
- A request held through reset is granted normally on the first cycle after rst deasserts.

Boundary conditions
- The port-0 and port-1 addresses are independent. Same-address read/write in consecutive cycles returns MEM's value after the prior write.
- MAX_HOLD=1 gives strict alternation under continuous contention.
- A request dropped without a grant is legal and ignored.

Optional Feature:
MEM_ARB_PERF_EN
- Defined: adds 16-bit saturating counters, output as ports.
  - gcnt0, gcnt1 (out, 16 bits): count accepted grants per port.
  - wcnt0, wcnt1 (out, 16 bits): count cycles where reqN=1 and gntN=0.
  - Counters are cleared by rst.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. Reset, then port 1 writes 0xDEADBEEF @0x010 -> mem_wen=0, mem_a=0x010, mem_d=0xDEADBEEF that cycle. Next cycle port 1 reads @0x010 -> rvalid1=1, rdata1=0xDEADBEEF one cycle later; rvalid0 stays 0.
2. Both ports request continuously from IDLE after reset (MAX_HOLD=4) -> grant sequence 0,0,0,0,1,1,1,1,0,... with exactly one gnt per cycle.
3. Port 0 streams 6 reads, port 1 idle -> 6 consecutive gnt0 with no forced switch; rvalid0 high for 6 consecutive cycles, each one cycle after its grant.
4. Both idle, then both request the same cycle twice, with an idle cycle between -> first winner is port 0 (rr_next=0), second winner is port 1.
5. Port 0 read accepted, rst=1 on the next cycle -> rvalid0=0, gnt0=gnt1=0, mem_wen=1. After release with req1 held -> gnt1=1 on the first cycle.
6. MEM_ARB_PERF_EN defined: run scenario 2 for 16 cycles -> gcnt0=8, gcnt1=8, wcnt0=8, wcnt1=8.
